seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed scan driver for a multi-digit common-anode 7-segment display. It holds one frame of BCD digits and drives one digit at a time onto a single shared 4-bit BCD bus, which feeds `seven_seg_dec` directly. Alongside the bus it drives the active-low digit enables and the decimal point. New frames are accepted through a load/ack handshake and applied only at frame boundaries, so the display never tears. Leading-zero blanking and an anti-ghosting guard interval are built in.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `PRESCALE`, 50000: clock cycles per digit slot (>= GUARD+2).
- `GUARD`, 16: cycles at the start of each slot with all enables off (>= 1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: one-cycle strobe that offers a new frame.
- `digits_in`  in  4*NUM_DIGITS: BCD digits; digit 0 (rightmost) is in [3:0].
- `dp_in`  in  NUM_DIGITS: decimal point per digit, active-high.
- `blank_lz`  in  1: enables leading-zero blanking (level, sampled every cycle).
- `bcd`  out  4: digit code to `seven_seg_dec`.
- `digit_en_n`  out  NUM_DIGITS: digit enables, active-low, at most one low at a time.
- `dp`  out  1: decimal point of the active digit.
- `load_ack`  out  1: one-cycle pulse when a pending frame is committed to display.
- `frame_start`  out  1: one-cycle pulse on the first cycle of slot 0.

## Operation
- **Registers**
  - `cnt` counts 0..PRESCALE-1.
  - `slot` counts 0..NUM_DIGITS-1; it increments when `cnt` wraps and itself wraps from NUM_DIGITS-1 to 0.
  - `pend_data`/`pend_dp`/`pend_valid` hold an offered frame; `disp_data`/`disp_dp` hold the frame being displayed.
- **Load**
  - `load`=1 captures `digits_in`/`dp_in` into the pending registers and sets `pend_valid`.
  - A new `load` while `pend_valid`=1 overwrites the pending frame (last wins) and produces no extra ack.
- **Commit**
  - Happens on the edge where `slot` wraps to 0 and `cnt` wraps to 0, only if `pend_valid`=1.
  - Copies pending into display, clears `pend_valid`, and pulses `load_ack` in that cycle.
  - If `load` and the commit edge coincide, the committed frame is the new `digits_in`; `pend_valid` ends 0.
- **Per-slot phases**
  - GUARD phase (`cnt` < GUARD): `digit_en_n` all 1, `dp`=0, `bcd` = BLANK_CODE (4'hF).
  - ON phase (`cnt` >= GUARD): `bcd` = `disp_data[slot]`, `dp` = `disp_dp[slot]`, `digit_en_n[slot]`=0, all other bits 1.
- **Blanking**
  - Digit i (i>0) is blanked when `blank_lz`=1 and every digit j>=i of `disp_data` is 0, unless `disp_dp[i]`=1.
  - Digit 0 is never blanked.
  - A blanked slot behaves as GUARD for its whole duration.
- **Out-of-range digits:** codes 10–15 are passed through unchanged; `seven_seg_dec` renders them as a dash.

## Timing
- All outputs are registers and reflect the `cnt`/`slot` values registered on the same edge; there is no combinational path from input to output.
- `load_ack` latency after `load` ranges from 1 cycle to one full frame (NUM_DIGITS*PRESCALE) cycles.
- Reset:
  - `cnt`=0, `slot`=0, display and pending frames all zero, `pend_valid`=0.
  - Outputs: `bcd`=4'hF, `digit_en_n` all 1, `dp`=0, `load_ack`=0, `frame_start`=0.
  - The first cycle after reset release has `cnt`=0 and `slot`=0 and pulses `frame_start`.
- Reset asserted mid-slot or mid-pending drops the pending frame; no ack is issued.
- `frame_start` and `load_ack` fall in the same cycle when a commit occurs.

## Structure
- Shared package `seg_pkg`: `BLANK_CODE`=4'hF, `BCD_W`=4, and a function returning the leading-zero blank mask over the digit vector.
- One sub-module, `seg_lz_mask`: combinational, inputs are the digit vector, dp vector and `blank_lz`; output is the NUM_DIGITS blank mask. Reusable by other display drivers.
- Top level contains the counters, the frame registers and the output registers.

## Test plan
Bench settings: NUM_DIGITS=4, PRESCALE=8, GUARD=2.
- **Reset values:** hold `rst` 3 cycles, then release → all outputs at reset values; `frame_start` pulses on the first cycle after release; `digit_en_n`=4'b1111 for 2 cycles, then 4'b1110 with `bcd`=0.
- **Basic scan:** `load` 0x1234 with dp=0 → ack at the next frame boundary. Next frame shows slot 0 `bcd`=4, `digit_en_n`=1110; slot 1 `bcd`=3, `digit_en_n`=1101; slot 2 `bcd`=2; slot 3 `bcd`=1, `digit_en_n`=0111. Each ON phase is 6 cycles.
- **Last-wins:** `load` 0x1111, then `load` 0x2222 before the boundary → a single `load_ack`; the displayed frame is 0x2222.
- **Leading-zero blanking:** `load` 0x0050 with `blank_lz`=1 → slots 2 and 3 keep all enables high; slots 0/1 show 0/5. `blank_lz`=0 → all four digits lit. `dp_in`=4'b0100 → slot 2 is lit showing 0 with `dp`=1.
- **Coincident load:** assert `load` 0x9876 exactly on the commit edge → `load_ack` in that cycle, 0x9876 displayed in that frame, `pend_valid`=0.
- **Reset mid-operation:** `load` 0x4321, assert `rst` before the boundary → no ack; the display stays 0x0000 through the following frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for 7-segment display drivers: code widths, the blank
// code and the leading-zero blank mask helper.
package seg_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    // Bit i is set when digit i and every digit above it are zero, blanking is
    // enabled and digit i has no decimal point. Digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [BCD_W*MAX_DIGITS-1:0] digits,
        input logic [MAX_DIGITS-1:0]       dps,
        input logic                        blank_lz,
        input int                          num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zeros_above;
        mask        = '0;
        zeros_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < num_digits) begin
                zeros_above = zeros_above && (digits[i*BCD_W +: BCD_W] == '0);
                mask[i]     = blank_lz && zeros_above && !dps[i];
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask over a BCD digit vector; purely combinational so any
// display driver can place it in front of its own output registers.
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]       dp_i,
    input  logic                        blank_lz_i,
    output logic [NUM_DIGITS-1:0]       mask_o
);

    always_comb begin
        mask_o = NUM_DIGITS'(lz_mask((BCD_W*MAX_DIGITS)'(digits_i),
                                     MAX_DIGITS'(dp_i), blank_lz_i, NUM_DIGITS));
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with
// tear-free frame loading, leading-zero blanking and an anti-ghosting guard.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        blank_lz,
    output logic [BCD_W-1:0]            bcd,
    output logic [NUM_DIGITS-1:0]       digit_en_n,
    output logic                        dp,
    output logic                        load_ack,
    output logic                        frame_start
);

    localparam int CNT_W  = $clog2(PRESCALE);
    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(GUARD);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic                        run_q;
    logic [BCD_W*NUM_DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]       en_n_q, en_n_d;
    logic                        dp_q, dp_d, ack_q, ack_d, fs_q, fs_d;
    logic                        wrap_edge, commit, slot_on;
    logic [NUM_DIGITS-1:0]       blank_mask;

    seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .digits_i   (disp_data_q),
        .dp_i       (disp_dp_q),
        .blank_lz_i (blank_lz),
        .mask_o     (blank_mask)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        bcd_d        = BLANK_CODE;
        en_n_d       = '1;
        dp_d         = 1'b0;

        // The first edge after reset holds cnt/slot at 0 so that cycle opens a frame.
        wrap_edge = run_q && (cnt_q == CNT_LAST) && (slot_q == SLOT_LAST);
        if (!run_q) begin
            cnt_d  = '0;
            slot_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (load) begin
            pend_data_d  = digits_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
        commit = wrap_edge && (pend_valid_q || load);
        if (commit) begin
            disp_data_d  = load ? digits_in : pend_data_q;
            disp_dp_d    = load ? dp_in : pend_dp_q;
            pend_valid_d = 1'b0;
        end

        // A commit always lands on cnt_d == 0 (guard), so the display registers
        // are current whenever a digit is actually lit.
        slot_on = (cnt_d >= GUARD_END) && !blank_mask[slot_d];
        if (slot_on) begin
            bcd_d          = disp_data_q[slot_d*BCD_W +: BCD_W];
            en_n_d[slot_d] = 1'b0;
            dp_d           = disp_dp_q[slot_d];
        end
        ack_d = commit;
        fs_d  = !run_q || wrap_edge;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            slot_q       <= '0;
            run_q        <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            bcd_q        <= BLANK_CODE;
            en_n_q       <= '1;
            dp_q         <= 1'b0;
            ack_q        <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            run_q        <= 1'b1;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            bcd_q        <= bcd_d;
            en_n_q       <= en_n_d;
            dp_q         <= dp_d;
            ack_q        <= ack_d;
            fs_q         <= fs_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_en_n  = en_n_q;
    assign dp          = dp_q;
    assign load_ack    = ack_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 8-cycle slots, 2-cycle guard);
// inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int GD    = 2;
    localparam int FRAME = ND * PS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [4*ND-1:0] digits_in = '0;
    logic [ND-1:0] dp_in = '0;
    logic          blank_lz = 1'b0;
    logic [3:0]    bcd;
    logic [ND-1:0] digit_en_n;
    logic          dp, load_ack, frame_start;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;   // cycles since the first frame_start after reset
    int ack_seen = 0;

    seg_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PS), .GUARD(GD)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .bcd         (bcd),
        .digit_en_n  (digit_en_n),
        .dp          (dp),
        .load_ack    (load_ack),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            pos++;
            if (load_ack === 1'b1) ack_seen++;
        end
    endtask

    task automatic goto(input int target);
        while (pos < target) step(1);
    endtask

    task automatic do_load(input logic [15:0] data, input logic [3:0] dps);
        load      = 1'b1;
        digits_in = data;
        dp_in     = dps;
        step(1);
        load = 1'b0;
    endtask

    // Walks one whole frame from its first cycle, checking every cycle against
    // the hand-given digits, lit mask and decimal points.
    task automatic scan_frame(input string name, input logic [15:0] dig,
                              input logic [3:0] lit, input logic [3:0] dps,
                              input logic exp_ack);
        int         s;
        int         c;
        logic       on;
        logic [3:0] e_bcd;
        logic [3:0] e_en;
        logic       e_dp;
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 0; i < FRAME; i++) begin
            s     = i / PS;
            c     = i % PS;
            on    = (c >= GD) && lit[s];
            e_bcd = on ? dig[s*4 +: 4] : 4'hF;
            e_en  = on ? ~(one << s) : 4'hF;
            e_dp  = on ? dps[s] : 1'b0;
            check($sformatf("%s outputs i=%0d", name, i),
                  {bcd, digit_en_n, dp, frame_start}, {e_bcd, e_en, e_dp, (i == 0)});
            check($sformatf("%s load_ack i=%0d", name, i),
                  load_ack, (i == 0) ? exp_ack : 1'b0);
            step(1);
        end
    endtask

    initial begin
        // Reset held for three rising edges.
        repeat (3) @(negedge clk);
        check("reset outputs", {bcd, digit_en_n, dp, frame_start}, {4'hF, 4'hF, 1'b0, 1'b0});
        check("reset load_ack", load_ack, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        pos = 0;

        // Frame 0: zero display, all digits lit, 2 guard cycles then 1110/0.
        scan_frame("reset frame", 16'h0000, 4'b1111, 4'b0000, 1'b0);

        // Basic scan.
        do_load(16'h1234, 4'b0000);
        ack_seen = 0;
        goto(2*FRAME - 1);
        check("basic no early ack", ack_seen, 0);
        step(1);
        scan_frame("basic", 16'h1234, 4'b1111, 4'b0000, 1'b1);

        // Last-wins.
        do_load(16'h1111, 4'b0000);
        step(5);
        do_load(16'h2222, 4'b0000);
        ack_seen = 0;
        goto(4*FRAME - 1);
        check("lastwins no early ack", ack_seen, 0);
        step(1);
        scan_frame("lastwins", 16'h2222, 4'b1111, 4'b0000, 1'b1);
        check("lastwins no second ack", load_ack, 1'b0);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        goto(6*FRAME);
        scan_frame("lz on", 16'h0050, 4'b0011, 4'b0000, 1'b1);
        blank_lz = 1'b0;
        scan_frame("lz off", 16'h0050, 4'b1111, 4'b0000, 1'b0);
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0100);
        goto(9*FRAME);
        scan_frame("lz dp", 16'h0050, 4'b0111, 4'b0100, 1'b1);
        blank_lz = 1'b0;

        // Load coinciding with the commit edge.
        goto(11*FRAME - 1);
        do_load(16'h9876, 4'b0000);
        scan_frame("coincident", 16'h9876, 4'b1111, 4'b0000, 1'b1);
        ack_seen = 0;
        goto(13*FRAME);
        check("coincident pend cleared", ack_seen, 0);

        // Reset while a frame is pending.
        do_load(16'h4321, 4'b0000);
        step(3);
        rst = 1'b1;
        ack_seen = 0;
        step(2);
        check("midreset outputs", {bcd, digit_en_n, dp, frame_start}, {4'hF, 4'hF, 1'b0, 1'b0});
        rst = 1'b0;
        step(1);
        check("midreset no ack", ack_seen, 0);
        pos = 0;
        scan_frame("post reset 1", 16'h0000, 4'b1111, 4'b0000, 1'b0);
        scan_frame("post reset 2", 16'h0000, 4'b1111, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
